// File: rtl/vec_deser_pkg.sv
// Shared types for the serial stimulus deserializer.
// Frame state encoding and width limits.
package vec_deser_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_PARITY,
    ST_HOLD
  } deser_state_t;

  localparam int VEC_W_MAX = 16;

endpackage

// File: rtl/vec_deserializer.sv
// Serial-to-parallel receiver: LSB-first bits into a vector,
// optional even parity, valid/ready delivery, frame counter.
module vec_deserializer
  import vec_deser_pkg::*;
#(
  parameter int VEC_W     = 8,
  parameter bit PARITY_EN = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_valid,
  input  logic             sin_data,
  input  logic             sin_sync,
  output logic             sin_ready,
  output logic [VEC_W-1:0] vec,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic             err_parity,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int CW = $clog2(VEC_W);
  localparam logic [CW-1:0] LAST = CW'(VEC_W - 1);

  deser_state_t     state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [VEC_W-1:0] shift_q, shift_d;
  logic [VEC_W-1:0] vec_d;
  logic             err_d;
  logic [CNT_W-1:0] fcnt_d;

  assign sin_ready = (state_q != ST_HOLD);
  assign vec_valid = (state_q == ST_HOLD);

  // Next-state: sync beats a beat, HOLD blocks new input.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    vec_d   = vec;
    err_d   = 1'b0;
    fcnt_d  = frame_cnt;
    case (state_q)
      ST_COLLECT: begin
        if (sin_sync) begin
          cnt_d = '0;
        end else if (sin_valid) begin
          shift_d[cnt_q] = sin_data;
          if (cnt_q == LAST) begin
            cnt_d = '0;
            if (PARITY_EN) begin
              state_d = ST_PARITY;
            end else begin
              vec_d   = shift_d;
              state_d = ST_HOLD;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (sin_sync) begin
          cnt_d   = '0;
          state_d = ST_COLLECT;
        end else if (sin_valid) begin
          cnt_d = '0;
          if ((^shift_q) ^ sin_data) begin
            err_d   = 1'b1;
            state_d = ST_COLLECT;
          end else begin
            vec_d   = shift_q;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (vec_ready) begin
          fcnt_d  = frame_cnt + CNT_W'(1);
          state_d = ST_COLLECT;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_COLLECT;
      end
    endcase
  end

  // State, shift, output vector and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_COLLECT;
      cnt_q      <= '0;
      shift_q    <= '0;
      vec        <= '0;
      err_parity <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      vec        <= vec_d;
      err_parity <= err_d;
      frame_cnt  <= fcnt_d;
    end
  end

  a_hold_stable: assert property (
    @(posedge clk) disable iff (rst)
    vec_valid && !vec_ready |=> vec_valid && $stable(vec));

  a_err_pulse: assert property (
    @(posedge clk) disable iff (rst)
    err_parity |=> !err_parity);

  a_no_ready_in_hold: assert property (
    @(posedge clk) disable iff (rst)
    vec_valid |-> !sin_ready);

endmodule

// File: tb/tb_vec_deserializer.sv
// Directed bench for vec_deserializer.
// Second instance with a 2-bit counter checks wrap.
module tb_vec_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin_valid;
  logic       sin_data;
  logic       sin_sync;
  logic       vec_ready;
  logic       sin_ready, vec_valid, err_parity;
  logic [7:0] vec;
  logic [15:0] frame_cnt;
  logic       sin_ready2, vec_valid2, err_parity2;
  logic [7:0] vec2;
  logic [1:0] frame_cnt2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vec_deserializer #(.VEC_W(8), .PARITY_EN(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .sin_valid(sin_valid), .sin_data(sin_data), .sin_sync(sin_sync),
    .sin_ready(sin_ready), .vec(vec), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .err_parity(err_parity),
    .frame_cnt(frame_cnt)
  );

  vec_deserializer #(.VEC_W(8), .PARITY_EN(1'b1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .sin_valid(sin_valid), .sin_data(sin_data), .sin_sync(sin_sync),
    .sin_ready(sin_ready2), .vec(vec2), .vec_valid(vec_valid2),
    .vec_ready(vec_ready), .err_parity(err_parity2),
    .frame_cnt(frame_cnt2)
  );

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic b);
    sin_valid = 1'b1;
    sin_data  = b;
    tick();
    sin_valid = 1'b0;
    sin_data  = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] v);
    for (int i = 0; i < 8; i++) beat(v[i]);
  endtask

  task automatic handshake();
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sin_valid = 1'b0;
    sin_data = 1'b0;
    sin_sync = 1'b0;
    vec_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: load a frame, then reset mid-stream
    send_data(8'h5A); beat(1'b0);
    handshake();
    beat(1'b1); beat(1'b0); beat(1'b1);
    rst = 1'b1;
    #1;
    check("rst_vec", 16'(vec), 16'h00);
    check("rst_vv", 16'(vec_valid), 16'h0);
    check("rst_fcnt", frame_cnt, 16'h0);
    check("rst_rdy", 16'(sin_ready), 16'h1);
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    check("rel_rdy", 16'(sin_ready), 16'h1);
    check("rel_vec", 16'(vec), 16'h00);
    check("rel_err", 16'(err_parity), 16'h0);

    // 2: good frame A5, parity 0
    send_data(8'hA5);
    check("a5_pre_vv", 16'(vec_valid), 16'h0);
    beat(1'b0);
    check("a5_vv", 16'(vec_valid), 16'h1);
    check("a5_vec", 16'(vec), 16'hA5);
    check("a5_rdy", 16'(sin_ready), 16'h0);
    check("a5_err", 16'(err_parity), 16'h0);
    handshake();
    check("a5_hs_vv", 16'(vec_valid), 16'h0);
    check("a5_hs_fcnt", frame_cnt, 16'd1);
    check("a5_hs_rdy", 16'(sin_ready), 16'h1);
    check("a5_hs_vec", 16'(vec), 16'hA5);

    // 3: bad parity on 01
    send_data(8'h01); beat(1'b0);
    check("bp_err", 16'(err_parity), 16'h1);
    check("bp_vv", 16'(vec_valid), 16'h0);
    check("bp_vec", 16'(vec), 16'hA5);
    check("bp_rdy", 16'(sin_ready), 16'h1);
    tick();
    check("bp_err_off", 16'(err_parity), 16'h0);
    check("bp_fcnt", frame_cnt, 16'd1);

    // 4: backpressure on 3C, then C3
    send_data(8'h3C); beat(1'b0);
    sin_valid = 1'b1;
    sin_data = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bk_vec", 16'(vec), 16'h3C);
      check("bk_rdy", 16'(sin_ready), 16'h0);
    end
    check("bk_vv", 16'(vec_valid), 16'h1);
    sin_valid = 1'b0;
    sin_data = 1'b0;
    handshake();
    check("bk_fcnt", frame_cnt, 16'd2);
    send_data(8'hC3); beat(1'b0);
    check("c3_vv", 16'(vec_valid), 16'h1);
    check("c3_vec", 16'(vec), 16'hC3);
    handshake();
    check("c3_fcnt", frame_cnt, 16'd3);

    // 5: resync with a simultaneous beat, then 81
    beat(1'b1); beat(1'b1); beat(1'b1); beat(1'b1);
    sin_sync = 1'b1;
    beat(1'b1);
    sin_sync = 1'b0;
    send_data(8'h81);
    check("rs_pre_vv", 16'(vec_valid), 16'h0);
    beat(1'b0);
    check("rs_vv", 16'(vec_valid), 16'h1);
    check("rs_vec", 16'(vec), 16'h81);
    check("rs_err", 16'(err_parity), 16'h0);
    handshake();
    check("rs_fcnt", frame_cnt, 16'd4);
    check("rs_err2", 16'(err_parity), 16'h0);

    // 6: counter wrap on the 2-bit instance
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("wr_rst", 16'(frame_cnt2), 16'd0);
    for (int k = 1; k <= 5; k++) begin
      logic [7:0] v;
      logic [1:0] e2;
      v = 8'(k * 8'h11);
      send_data(v); beat(^v);
      check("wr_vec", 16'(vec2), 16'(v));
      handshake();
      e2 = 2'(k);
      check("wr_fcnt2", 16'(frame_cnt2), 16'(e2));
      check("wr_fcnt", frame_cnt, 16'(k));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
